// File: rtl/mfcc_framer.sv
// rtl/mfcc_framer.sv - PCM framer with circular buffer, windowing and zero padding for the FFT core
module mfcc_framer #(
    parameter int NFFT        = 512,
    parameter int NFFT_LOG2   = $clog2(NFFT),
    parameter int INPUT_WIDTH = 16,
    parameter int FRAME_LEN   = 400,
    parameter int HOP         = 160,
    parameter int WIN_WIDTH   = 16,
    // Window ROM image built from tables/window.hex; entry k sits at [k*WIN_WIDTH +: WIN_WIDTH]
    parameter logic [FRAME_LEN*WIN_WIDTH-1:0] WIN_INIT = {FRAME_LEN{{WIN_WIDTH{1'b1}}}}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_valid_i,
    output logic                          sample_ready_o,
    input  logic signed [INPUT_WIDTH-1:0] sample_i,
    input  logic                          flush_i,
    output logic                          fft_in_valid_o,
    output logic [NFFT_LOG2-1:0]          fft_frame_ptr_o,
    output logic signed [INPUT_WIDTH-1:0] fft_real_o,
    output logic                          fft_start_o,
    input  logic                          fft_done_i,
    output logic                          busy_o,
    output logic [15:0]                   frame_count_o
);

    localparam int FW     = NFFT_LOG2 + 1;
    localparam int WIN_AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int PW     = INPUT_WIDTH + WIN_WIDTH + 1;

    localparam logic [FW-1:0]        FILL_MAX   = FW'(NFFT);
    localparam logic [FW-1:0]        FILL_FRAME = FW'(FRAME_LEN);
    localparam logic [FW-1:0]        FILL_HOP   = FW'(HOP);
    localparam logic [FW-1:0]        FILL_ONE   = FW'(1);
    localparam logic [FW-1:0]        PAD_START  = FW'(FRAME_LEN);
    localparam logic [NFFT_LOG2-1:0] PTR_LAST   = NFFT_LOG2'(NFFT - 1);
    localparam logic [NFFT_LOG2-1:0] PTR_ONE    = NFFT_LOG2'(1);
    localparam logic [NFFT_LOG2-1:0] BASE_HOP   = NFFT_LOG2'(HOP);
    localparam logic signed [PW-1:0] ROUND      = PW'(1) << (WIN_WIDTH - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_EMIT,
        S_DRAIN,
        S_WAIT_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [NFFT_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [NFFT_LOG2-1:0]   rd_base_q, rd_base_d;
    logic [NFFT_LOG2-1:0]   ptr_q, ptr_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic [15:0]            frame_count_q, frame_count_d;
    logic                   start_q, start_d;

    // Stage A: buffer/ROM read; stage B: windowed output register
    logic                          a_valid_q;
    logic                          a_pad_q;
    logic [NFFT_LOG2-1:0]          a_ptr_q;
    logic signed [INPUT_WIDTH-1:0] a_sample_q;
    logic [WIN_WIDTH-1:0]          a_coeff_q;
    logic                          b_valid_q;
    logic [NFFT_LOG2-1:0]          b_ptr_q;
    logic signed [INPUT_WIDTH-1:0] b_real_q;

    logic [INPUT_WIDTH-1:0] buf_mem [NFFT];
    logic [WIN_WIDTH-1:0]   win_rom [FRAME_LEN];

    logic                          accept;
    logic                          flush_now;
    logic                          done_now;
    logic                          is_pad;
    logic signed [PW-1:0]          samp_ext;
    logic signed [PW-1:0]          coef_ext;
    logic signed [INPUT_WIDTH-1:0] win_out;

    for (genvar g = 0; g < FRAME_LEN; g++) begin : g_rom
        assign win_rom[g] = WIN_INIT[g*WIN_WIDTH +: WIN_WIDTH];
    end

    // A slot is free whenever fill is below the buffer depth; frames only occupy filled slots
    assign sample_ready_o = (fill_q < FILL_MAX);
    assign accept         = sample_valid_i && sample_ready_o;
    assign flush_now      = flush_i && (state_q == S_FILL);
    assign done_now       = fft_done_i && (state_q == S_WAIT_DONE);
    assign is_pad         = ({1'b0, ptr_q} >= PAD_START);

    // Signed sample times unsigned Q0.16 coefficient, rounded half-up, then truncated
    assign samp_ext = PW'(a_sample_q);
    assign coef_ext = {{(PW - WIN_WIDTH){1'b0}}, a_coeff_q};
    assign win_out  = INPUT_WIDTH'((samp_ext * coef_ext + ROUND) >>> WIN_WIDTH);

    // Next-state: pointer/fill bookkeeping and frame sequencing
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_base_d     = rd_base_q;
        fill_d        = fill_q;
        ptr_d         = ptr_q;
        start_d       = 1'b0;
        frame_count_d = frame_count_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            fill_d   = fill_q + FILL_ONE;
        end
        if (done_now) begin
            rd_base_d = rd_base_q + BASE_HOP;
            fill_d    = fill_d - FILL_HOP;
        end

        case (state_q)
            S_FILL: begin
                if (flush_now) begin
                    wr_ptr_d  = '0;
                    rd_base_d = '0;
                    fill_d    = '0;
                end else if (fill_q >= FILL_FRAME) begin
                    state_d = S_EMIT;
                    ptr_d   = '0;
                end
            end
            S_EMIT: begin
                ptr_d = ptr_q + PTR_ONE;
                if (ptr_q == PTR_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Stage A empty means the final sample is in stage B this cycle
                if (!a_valid_q) begin
                    state_d       = S_WAIT_DONE;
                    start_d       = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                end
            end
            S_WAIT_DONE: begin
                if (fft_done_i) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_FILL;
            wr_ptr_q      <= '0;
            rd_base_q     <= '0;
            fill_q        <= '0;
            ptr_q         <= '0;
            start_q       <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_base_q     <= rd_base_d;
            fill_q        <= fill_d;
            ptr_q         <= ptr_d;
            start_q       <= start_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Sample buffer write and stage A data read (data path, no reset needed)
    always_ff @(posedge clk) begin
        if (accept && !flush_now) begin
            buf_mem[wr_ptr_q] <= sample_i;
        end
        a_sample_q <= buf_mem[rd_base_q + ptr_q];
        a_coeff_q  <= is_pad ? '0 : win_rom[ptr_q[WIN_AW-1:0]];
    end

    // Stage A control: tags each issued pointer with valid and pad flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_valid_q <= 1'b0;
            a_pad_q   <= 1'b0;
            a_ptr_q   <= '0;
        end else begin
            a_valid_q <= (state_q == S_EMIT);
            a_pad_q   <= is_pad;
            a_ptr_q   <= ptr_q;
        end
    end

    // Stage B: registered FFT input, zero at pad positions
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_valid_q <= 1'b0;
            b_ptr_q   <= '0;
            b_real_q  <= '0;
        end else begin
            b_valid_q <= a_valid_q;
            b_ptr_q   <= a_ptr_q;
            b_real_q  <= a_pad_q ? '0 : win_out;
        end
    end

    assign fft_in_valid_o  = b_valid_q;
    assign fft_frame_ptr_o = b_ptr_q;
    assign fft_real_o      = b_real_q;
    assign fft_start_o     = start_q;
    assign busy_o          = (state_q != S_FILL);
    assign frame_count_o   = frame_count_q;

endmodule

// File: tb/tb_mfcc_framer.sv
// tb/tb_mfcc_framer.sv - directed self-checking bench for mfcc_framer
module tb_mfcc_framer;

    localparam int NFFT      = 512;
    localparam int FRAME_LEN = 400;
    localparam int HOP       = 160;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               sample_valid_i;
    logic               sample_ready_o;
    logic signed [15:0] sample_i;
    logic               flush_i;
    logic               fft_in_valid_o;
    logic [8:0]         fft_frame_ptr_o;
    logic signed [15:0] fft_real_o;
    logic               fft_start_o;
    logic               fft_done_i;
    logic               busy_o;
    logic [15:0]        frame_count_o;

    logic               h_valid_i;
    logic               h_ready_o;
    logic signed [15:0] h_sample_i;
    logic               h_in_valid_o;
    logic [8:0]         h_ptr_o;
    logic signed [15:0] h_real_o;
    logic               h_start_o;
    logic               h_busy_o;
    logic [15:0]        h_count_o;

    mfcc_framer dut (
        .clk(clk), .rst_n(rst_n),
        .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o), .sample_i(sample_i),
        .flush_i(flush_i),
        .fft_in_valid_o(fft_in_valid_o), .fft_frame_ptr_o(fft_frame_ptr_o), .fft_real_o(fft_real_o),
        .fft_start_o(fft_start_o), .fft_done_i(fft_done_i),
        .busy_o(busy_o), .frame_count_o(frame_count_o)
    );

    mfcc_framer #(.WIN_INIT({400{16'h8000}})) dut_h (
        .clk(clk), .rst_n(rst_n),
        .sample_valid_i(h_valid_i), .sample_ready_o(h_ready_o), .sample_i(h_sample_i),
        .flush_i(flush_i),
        .fft_in_valid_o(h_in_valid_o), .fft_frame_ptr_o(h_ptr_o), .fft_real_o(h_real_o),
        .fft_start_o(h_start_o), .fft_done_i(fft_done_i),
        .busy_o(h_busy_o), .frame_count_o(h_count_o)
    );

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    logic signed [15:0] feed_q[$];
    logic signed [15:0] h_q[$];
    logic signed [15:0] cap_real [NFFT];
    logic signed [15:0] h_real [NFFT];
    int  acc_n, model_fill, ready_bad, low_n;
    bit  prev_acc, prev_done;
    int  done_at, done_delay;
    int  frame_n, gap_n, last_valid_cyc, last_ptr, start_n, coinc_n, valid_total;
    int  fr_first [8];
    int  fr_cnt   [8];
    int  fr_gap   [8];
    bit  fr_ramp  [8];
    bit  fr_const [8];
    bit  fr_pad   [8];

    // One clock: observe at negedge, account for the previous edge, drive inputs for the next edge
    task automatic tick();
        bit rok, cok, pok;
        @(negedge clk);
        cyc++;
        if (prev_acc) begin
            acc_n++;
            model_fill++;
        end
        if (prev_done) model_fill -= HOP;
        if (rst_n && (sample_ready_o !== (model_fill < NFFT))) ready_bad++;
        if (rst_n && !sample_ready_o) low_n++;
        if (fft_in_valid_o) begin
            if (fft_frame_ptr_o != 0 && (last_valid_cyc != cyc - 1 || last_ptr != int'(fft_frame_ptr_o) - 1))
                gap_n++;
            cap_real[fft_frame_ptr_o] = fft_real_o;
            frame_n++;
            valid_total++;
            last_valid_cyc = cyc;
            last_ptr = int'(fft_frame_ptr_o);
        end
        if (fft_start_o) begin
            if (fft_in_valid_o) coinc_n++;
            rok = 1'b1; cok = 1'b1; pok = 1'b1;
            for (int i = 0; i < NFFT; i++) begin
                if (i < FRAME_LEN) begin
                    if (int'(cap_real[i]) != int'(cap_real[0]) + i) rok = 1'b0;
                    if (cap_real[i] !== cap_real[0]) cok = 1'b0;
                end else if (cap_real[i] !== 16'sd0) begin
                    pok = 1'b0;
                end
            end
            if (start_n < 8) begin
                fr_first[start_n] = int'(cap_real[0]);
                fr_cnt[start_n]   = frame_n;
                fr_gap[start_n]   = cyc - last_valid_cyc;
                fr_ramp[start_n]  = rok;
                fr_const[start_n] = cok;
                fr_pad[start_n]   = pok;
            end
            start_n++;
            frame_n = 0;
            if (done_delay > 0) done_at = cyc + done_delay;
        end
        if (h_in_valid_o) h_real[h_ptr_o] = h_real_o;

        fft_done_i     = (cyc == done_at);
        sample_valid_i = (feed_q.size() > 0);
        sample_i       = (feed_q.size() > 0) ? feed_q[0] : 16'sd0;
        prev_acc       = sample_valid_i && sample_ready_o;
        if (prev_acc) void'(feed_q.pop_front());
        prev_done      = fft_done_i;
        h_valid_i      = (h_q.size() > 0);
        h_sample_i     = (h_q.size() > 0) ? h_q[0] : 16'sd0;
        if (h_valid_i && h_ready_o) void'(h_q.pop_front());
    endtask

    task automatic clear_obs();
        acc_n = 0; model_fill = 0; ready_bad = 0; low_n = 0;
        prev_acc = 1'b0; prev_done = 1'b0;
        done_at = -1; done_delay = 0;
        frame_n = 0; gap_n = 0; last_valid_cyc = -10; last_ptr = -10;
        start_n = 0; coinc_n = 0; valid_total = 0;
        for (int i = 0; i < 8; i++) begin
            fr_first[i] = -99999; fr_cnt[i] = -1; fr_gap[i] = -1;
            fr_ramp[i] = 1'b0; fr_const[i] = 1'b0; fr_pad[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush_i = 1'b0;
        feed_q.delete();
        h_q.delete();
        done_at = -1;
        repeat (3) tick();
        clear_obs();
        rst_n = 1'b1;
    endtask

    task automatic run_until_starts(input int n, input int budget);
        for (int i = 0; i < budget && start_n < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        tests++; if (fft_in_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", fft_in_valid_o); end
        tests++; if (fft_frame_ptr_o !== 9'd0) begin fails++; $display("FAIL reset_ptr: got %0d expected 0", fft_frame_ptr_o); end
        tests++; if (fft_real_o !== 16'sd0) begin fails++; $display("FAIL reset_real: got %0d expected 0", fft_real_o); end
        tests++; if (fft_start_o !== 1'b0) begin fails++; $display("FAIL reset_start: got %0b expected 0", fft_start_o); end
        tests++; if (frame_count_o !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", frame_count_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy_o); end
        tests++; if (sample_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b expected 1", sample_ready_o); end
        clear_obs();
        rst_n = 1'b1;
        tick();
        tests++; if (sample_ready_o !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %0b expected 1", sample_ready_o); end
    endtask

    task automatic test_basic_frame();
        do_reset();
        for (int i = 0; i < FRAME_LEN; i++) feed_q.push_back(16'sd1000);
        run_until_starts(1, 3000);
        repeat (3) tick();
        tests++; if (start_n !== 1) begin fails++; $display("FAIL basic_starts: got %0d expected 1", start_n); end
        tests++; if (valid_total !== NFFT) begin fails++; $display("FAIL basic_valids: got %0d expected %0d", valid_total, NFFT); end
        tests++; if (gap_n !== 0) begin fails++; $display("FAIL basic_gaps: got %0d expected 0", gap_n); end
        tests++; if (fr_first[0] !== 1000) begin fails++; $display("FAIL basic_first: got %0d expected 1000", fr_first[0]); end
        tests++; if (fr_const[0] !== 1'b1) begin fails++; $display("FAIL basic_data: got %0b expected 1", fr_const[0]); end
        tests++; if (fr_pad[0] !== 1'b1) begin fails++; $display("FAIL basic_pad: got %0b expected 1", fr_pad[0]); end
        tests++; if (fr_cnt[0] !== NFFT) begin fails++; $display("FAIL basic_frame_len: got %0d expected %0d", fr_cnt[0], NFFT); end
        tests++; if (fr_gap[0] !== 1) begin fails++; $display("FAIL basic_start_delay: got %0d expected 1", fr_gap[0]); end
        tests++; if (coinc_n !== 0) begin fails++; $display("FAIL basic_start_overlap: got %0d expected 0", coinc_n); end
        tests++; if (frame_count_o !== 16'd1) begin fails++; $display("FAIL basic_count: got %0d expected 1", frame_count_o); end
        tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL basic_busy_wait: got %0b expected 1", busy_o); end
    endtask

    task automatic test_window_math();
        do_reset();
        feed_q.push_back(-16'sd32768);
        feed_q.push_back(16'sd1000);
        feed_q.push_back(16'sd32767);
        for (int i = 3; i < FRAME_LEN; i++) feed_q.push_back(16'sd0);
        h_q.push_back(16'sd1000);
        h_q.push_back(-16'sd1);
        h_q.push_back(16'sd3);
        h_q.push_back(-16'sd3);
        for (int i = 4; i < FRAME_LEN; i++) h_q.push_back(16'sd0);
        run_until_starts(1, 3000);
        repeat (5) tick();
        tests++; if (cap_real[0] !== -16'sd32767) begin fails++; $display("FAIL win_neg_full: got %0d expected -32767", cap_real[0]); end
        tests++; if (cap_real[1] !== 16'sd1000) begin fails++; $display("FAIL win_1000_full: got %0d expected 1000", cap_real[1]); end
        tests++; if (cap_real[2] !== 16'sd32767) begin fails++; $display("FAIL win_max_full: got %0d expected 32767", cap_real[2]); end
        tests++; if (h_real[0] !== 16'sd500) begin fails++; $display("FAIL win_1000_half: got %0d expected 500", h_real[0]); end
        tests++; if (h_real[1] !== 16'sd0) begin fails++; $display("FAIL win_m1_half: got %0d expected 0", h_real[1]); end
        tests++; if (h_real[2] !== 16'sd2) begin fails++; $display("FAIL win_3_half: got %0d expected 2", h_real[2]); end
        tests++; if (h_real[3] !== -16'sd1) begin fails++; $display("FAIL win_m3_half: got %0d expected -1", h_real[3]); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 1200; i++) feed_q.push_back(16'(i));
        done_delay = 10;
        run_until_starts(4, 5000);
        tests++; if (start_n < 4) begin fails++; $display("FAIL stream_starts: got %0d expected 4", start_n); end
        for (int n = 0; n < 4; n++) begin
            tests++; if (fr_first[n] !== HOP * n) begin fails++; $display("FAIL stream_first%0d: got %0d expected %0d", n, fr_first[n], HOP * n); end
            tests++; if (fr_ramp[n] !== 1'b1 || fr_pad[n] !== 1'b1) begin fails++; $display("FAIL stream_data%0d: got ramp=%0b pad=%0b expected 1 1", n, fr_ramp[n], fr_pad[n]); end
        end
        tests++; if (gap_n !== 0) begin fails++; $display("FAIL stream_gaps: got %0d expected 0", gap_n); end
        tests++; if (ready_bad !== 0) begin fails++; $display("FAIL stream_ready: got %0d wrong cycles expected 0", ready_bad); end
        tests++; if (!(low_n > 0)) begin fails++; $display("FAIL stream_full_seen: got %0d not-ready cycles expected >0", low_n); end
        tests++; if (coinc_n !== 0) begin fails++; $display("FAIL stream_start_overlap: got %0d expected 0", coinc_n); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 1200; i++) feed_q.push_back(16'(i));
        run_until_starts(1, 3000);
        repeat (200) tick();
        tests++; if (sample_ready_o !== 1'b0) begin fails++; $display("FAIL bp_ready: got %0b expected 0", sample_ready_o); end
        tests++; if (acc_n !== NFFT) begin fails++; $display("FAIL bp_accepted: got %0d expected %0d", acc_n, NFFT); end
        tests++; if (ready_bad !== 0) begin fails++; $display("FAIL bp_ready_model: got %0d wrong cycles expected 0", ready_bad); end
        done_at = cyc + 1;
        run_until_starts(2, 3000);
        tests++; if (fr_first[1] !== HOP) begin fails++; $display("FAIL bp_next_first: got %0d expected %0d", fr_first[1], HOP); end
        tests++; if (fr_ramp[1] !== 1'b1) begin fails++; $display("FAIL bp_next_data: got %0b expected 1", fr_ramp[1]); end
        tests++; if (frame_count_o !== 16'd2) begin fails++; $display("FAIL bp_count: got %0d expected 2", frame_count_o); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 200; i++) feed_q.push_back(16'sd99);
        for (int i = 0; i < 400 && feed_q.size() > 0; i++) tick();
        repeat (3) tick();
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL flush_in_fill: got busy %0b expected 0", busy_o); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        model_fill = 0;
        for (int i = 0; i < FRAME_LEN; i++) feed_q.push_back(16'sd7);
        for (int i = 0; i < 3000 && start_n < 1; i++) begin
            tick();
            flush_i = fft_in_valid_o && (fft_frame_ptr_o == 9'd50);
        end
        flush_i = 1'b0;
        done_at = cyc + 3;
        for (int i = 0; i < HOP; i++) feed_q.push_back(16'sd8);
        run_until_starts(2, 3000);
        tests++; if (fr_first[0] !== 7) begin fails++; $display("FAIL flush_first: got %0d expected 7", fr_first[0]); end
        tests++; if (fr_const[0] !== 1'b1 || fr_pad[0] !== 1'b1) begin fails++; $display("FAIL flush_data: got const=%0b pad=%0b expected 1 1", fr_const[0], fr_pad[0]); end
        tests++; if (cap_real[239] !== 16'sd7) begin fails++; $display("FAIL flush_emit_239: got %0d expected 7", cap_real[239]); end
        tests++; if (cap_real[240] !== 16'sd8) begin fails++; $display("FAIL flush_emit_240: got %0d expected 8", cap_real[240]); end
        tests++; if (cap_real[399] !== 16'sd8) begin fails++; $display("FAIL flush_emit_399: got %0d expected 8", cap_real[399]); end
        tests++; if (frame_count_o !== 16'd2) begin fails++; $display("FAIL flush_count: got %0d expected 2", frame_count_o); end
    endtask

    task automatic test_reset_mid_frame();
        int vt;
        do_reset();
        for (int i = 0; i < FRAME_LEN; i++) feed_q.push_back(16'(i));
        for (int i = 0; i < 2000 && !(fft_in_valid_o && fft_frame_ptr_o == 9'd98); i++) tick();
        rst_n = 1'b0;
        feed_q.delete();
        tick();
        tests++; if (fft_in_valid_o !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %0b expected 0", fft_in_valid_o); end
        tests++; if (frame_count_o !== 16'd0) begin fails++; $display("FAIL midrst_count: got %0d expected 0", frame_count_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %0b expected 0", busy_o); end
        rst_n = 1'b1;
        model_fill = 0;
        frame_n = 0;
        repeat (600) tick();
        tests++; if (start_n !== 0) begin fails++; $display("FAIL midrst_no_start: got %0d expected 0", start_n); end
        vt = valid_total;
        for (int i = 0; i < FRAME_LEN - 1; i++) feed_q.push_back(16'sd1);
        repeat (FRAME_LEN + 30) tick();
        tests++; if (valid_total !== vt) begin fails++; $display("FAIL midrst_fill_zero: got %0d valids expected %0d", valid_total, vt); end
        feed_q.push_back(16'sd1);
        run_until_starts(1, 2000);
        tests++; if (fr_first[0] !== 1 || fr_const[0] !== 1'b1) begin fails++; $display("FAIL midrst_next_frame: got first=%0d const=%0b expected 1 1", fr_first[0], fr_const[0]); end
        tests++; if (frame_count_o !== 16'd1) begin fails++; $display("FAIL midrst_count_after: got %0d expected 1", frame_count_o); end
    endtask

    initial begin
        rst_n = 1'b0;
        sample_valid_i = 1'b0;
        sample_i = '0;
        h_valid_i = 1'b0;
        h_sample_i = '0;
        flush_i = 1'b0;
        fft_done_i = 1'b0;
        clear_obs();
        test_reset();
        test_basic_frame();
        test_window_math();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mfcc_framer.md
Name: mfcc_framer

Overview:
- Front end of the MFCC chain; drives the FFT core's input and start interface.
- Accepts a stream of PCM samples into a circular buffer and slices overlapping frames of FRAME_LEN samples every HOP samples.
- Multiplies each sample by a window coefficient from ROM and zero-pads each frame to NFFT.
- Emits one sample per cycle (in_valid/frame_ptr/real_in), pulses start, waits for fft done, then retires HOP samples.

Parameters:
- NFFT, 512, FFT size and circular buffer depth; power of 2.
- NFFT_LOG2, $clog2(NFFT), pointer width.
- INPUT_WIDTH, 16, signed PCM sample width.
- FRAME_LEN, 400, samples per frame; must be ≤ NFFT.
- HOP, 160, frame advance; must be ≤ FRAME_LEN.
- WIN_WIDTH, 16, unsigned Q0.16 window coefficient width. ROM loaded from "tables/window.hex", FRAME_LEN entries.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, synchronous active-low reset.
- sample_valid_i, input, 1, PCM sample offered.
- sample_ready_o, output, 1, sample accepted when valid&&ready.
- sample_i, input, INPUT_WIDTH, signed PCM sample.
- flush_i, input, 1, discard buffered samples; honoured in FILL only.
- fft_in_valid_o, output, 1, windowed sample valid to FFT.
- fft_frame_ptr_o, output, NFFT_LOG2, natural-order index 0..NFFT-1.
- fft_real_o, output, INPUT_WIDTH, windowed sample.
- fft_start_o, output, 1, one-cycle start pulse.
- fft_done_i, input, 1, FFT finished frame (one-cycle pulse).
- busy_o, output, 1, high in every state except FILL.
- frame_count_o, output, 16, frames issued; wraps modulo 2^16.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=FILL; wr_ptr=rd_base=fill=0; emit ptr=0.
  - Output reset values: fft_in_valid_o=0, fft_frame_ptr_o=0, fft_real_o=0, fft_start_o=0, frame_count_o=0, busy_o=0.
  - sample_ready_o=1 during the first cycle after reset.
  - Reset mid-frame aborts emission; no start pulse is issued.
- Input side:
  - sample_ready_o = (fill < NFFT), combinational from registers.
  - Accept writes buf[wr_ptr]; wr_ptr++ wraps modulo NFFT; fill++.
  - Writes are legal in every state. They only target free slots, so the frame under emission is never corrupted.
- FILL:
  - When fill ≥ FRAME_LEN → EMIT, ptr=0.
  - flush_i in FILL: wr_ptr=rd_base=fill=0; takes priority over a same-cycle accept, which is dropped.
  - flush_i in other states is ignored.
- EMIT:
  - ptr counts 0..NFFT-1, one per cycle.
  - Stage A registers buf[(rd_base+ptr) mod NFFT], win[ptr], ptr, and a pad flag (ptr ≥ FRAME_LEN).
  - Stage B registers the outputs with fft_in_valid_o=1.
  - Latency from ptr issue to fft_in_valid_o is 2 cycles.
  - Exactly NFFT consecutive valid cycles, with no bubbles.
  - After ptr=NFFT-1 is issued → DRAIN.
- DRAIN:
  - Waits until the last valid leaves stage B.
  - Next cycle: fft_start_o=1 for exactly one cycle, frame_count_o++, → WAIT_DONE.
  - The start pulse is never coincident with fft_in_valid_o.
- WAIT_DONE:
  - On fft_done_i: rd_base += HOP (mod NFFT); fill -= HOP; → FILL.
  - Same-cycle accept: fill = fill + 1 − HOP.
  - fft_done_i outside WAIT_DONE is ignored.
- Window arithmetic:
  - prod = signed(sample) × unsigned coeff, 33-bit signed.
  - out = (prod + 2^15) >>> 16, truncated to INPUT_WIDTH; no saturation is needed.
  - Pad positions output 0 with fft_in_valid_o=1.
- A back-to-back frame starts immediately on return to FILL if fill ≥ FRAME_LEN still holds.

Test Plan:
1. Reset, then feed 400 samples of value 1000, with all window coefficients = 0xFFFF → 512 valids on consecutive cycles; real=1000 at ptr 0..399, 0 at 400..511; one start pulse 1 cycle after the last valid; frame_count_o=1.
2. Sample −32768 with coeff 0xFFFF → −32767. Sample 1000 with coeff 0x8000 → 500. Sample −1 with coeff 0x8000 → 0 (rounding check).
3. Stream a ramp 0,1,2,… continuously with coeff=0xFFFF, and pulse fft_done_i 10 cycles after each start → frame n starts with value 160·n. The ramp continues with no gaps at the wrap of the 512-deep buffer. sample_ready_o drops only when fill=512.
4. Hold fft_done_i low after a start with input still offered → fill saturates at 512 and sample_ready_o=0. No overwrite occurs, and the next frame data is correct after done.
5. Feed 200 samples, pulse flush_i in FILL, then feed 400 samples of value 7 → the emitted frame contains only 7s; pulsing flush_i during EMIT has no effect.
6. Assert rst_n=0 at ptr=100 of EMIT → next cycle fft_in_valid_o=0, no start pulse, fill=0, frame_count_o=0.
